// File: rtl/demux8_router_pkg.sv
// Shared definitions for the demux8_router slice.
//   NUM_DEST : number of sinks (8)
//   CODE_W   : destination code width (3)
//   state_t  : router FSM states (EMPTY / FULL / SKID)
//   onehot() : destination code -> one-hot sink select
package demux8_router_pkg;

  localparam int unsigned NUM_DEST = 8;
  localparam int unsigned CODE_W   = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  function automatic logic [NUM_DEST-1:0] onehot(input logic [CODE_W-1:0] code);
    logic [NUM_DEST-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux8_router_hold_reg.sv
// demux_hold_reg: one {code, data} holding entry for the router.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset (clears entry)
//   clear      in   synchronous clear (same effect as reset)
//   load       in   capture load_code/load_data this edge
//   load_code  in   CODE_W  code to capture
//   load_data  in   size    data to capture
//   code       out  CODE_W  held code
//   data       out  size    held data
module demux_hold_reg
  import demux8_router_pkg::*;
#(
  parameter int unsigned size = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [CODE_W-1:0] load_code,
  input  logic [size-1:0]   load_data,
  output logic [CODE_W-1:0] code,
  output logic [size-1:0]   data
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      code <= '0;
      data <= '0;
    end else if (load) begin
      code <= load_code;
      data <= load_data;
    end
  end

endmodule

// File: rtl/demux8_router.sv
// demux8_router: registered 1-to-8 distributor with valid/ready on both sides.
// A word plus 3-bit destination code is held and presented to exactly one sink.
// Optional feature: define DEMUX_SKID_EN to add a skid entry and a registered
// in_ready (no combinational ready path); otherwise a 2-state EMPTY/FULL FSM.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   in_data    in   size      word to route
//   in_code    in   3         destination index
//   in_valid   in   1         upstream offers a word
//   in_ready   out  1         block accepts this cycle
//   out_data   out  size      shared data bus to all sinks
//   out_valid  out  8         one-hot sink valid
//   out_ready  in   8         per-sink ready
//   busy       out  1         any word held
//   stall_cnt  out  STALL_W   saturating count of stalled cycles
module demux8_router
  import demux8_router_pkg::*;
#(
  parameter int unsigned size    = 8,
  parameter int unsigned STALL_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [size-1:0]     in_data,
  input  logic [CODE_W-1:0]   in_code,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [size-1:0]     out_data,
  output logic [NUM_DEST-1:0] out_valid,
  input  logic [NUM_DEST-1:0] out_ready,
  output logic                busy,
  output logic [STALL_W-1:0]  stall_cnt
);

  state_t            state, state_nxt;
  logic [CODE_W-1:0] code_q;
  logic [size-1:0]   data_q;
  logic              main_full;
  logic              addr_ready;
  logic              in_xfer;
  logic              out_xfer;
  logic              main_load;
  logic [CODE_W-1:0] main_code_src;
  logic [size-1:0]   main_data_src;

  // Main entry is occupied in FULL and in SKID.
  assign main_full  = (state != ST_EMPTY);
  // Only the addressed sink's ready matters.
  assign addr_ready = out_ready[code_q];
  assign out_xfer   = main_full & addr_ready;
  assign in_xfer    = in_valid & in_ready;
  assign out_valid  = main_full ? onehot(code_q) : '0;
  assign out_data   = data_q;
  assign busy       = main_full;

  demux_hold_reg #(.size(size)) u_main (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .load      (main_load),
    .load_code (main_code_src),
    .load_data (main_data_src),
    .code      (code_q),
    .data      (data_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

`ifdef DEMUX_SKID_EN
  logic [CODE_W-1:0] skid_code;
  logic [size-1:0]   skid_data;
  logic              skid_load;
  logic              skid_clear;
  logic              ready_q;

  demux_hold_reg #(.size(size)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clear     (skid_clear),
    .load      (skid_load),
    .load_code (in_code),
    .load_data (in_data),
    .code      (skid_code),
    .data      (skid_data)
  );

  // Ready is registered from the next state: accept whenever the skid entry
  // will be free, so a word offered during a stall lands in skid.
  always_ff @(posedge clk) begin
    if (reset) ready_q <= 1'b1;
    else       ready_q <= (state_nxt != ST_SKID);
  end
  assign in_ready = ready_q;

  always_comb begin
    state_nxt     = state;
    main_load     = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    main_code_src = in_code;
    main_data_src = in_data;
    case (state)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_load = 1'b1;
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          if (in_xfer) main_load = 1'b1;
          else         state_nxt = ST_EMPTY;
        end else if (in_xfer) begin
          skid_load = 1'b1;
          state_nxt = ST_SKID;
        end
      end
      ST_SKID: begin
        // Skid drains into main first so delivery order is preserved.
        if (out_xfer) begin
          main_load     = 1'b1;
          main_code_src = skid_code;
          main_data_src = skid_data;
          if (in_xfer) begin
            skid_load = 1'b1;
          end else begin
            skid_clear = 1'b1;
            state_nxt  = ST_FULL;
          end
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end
`else
  // Combinational ready: a held word leaving this cycle frees the entry.
  assign in_ready = ~main_full | addr_ready;

  always_comb begin
    state_nxt     = state;
    main_load     = 1'b0;
    main_code_src = in_code;
    main_data_src = in_data;
    case (state)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_load = 1'b1;
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (in_xfer)       main_load = 1'b1;
        else if (out_xfer) state_nxt = ST_EMPTY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (main_full && !addr_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_demux8_router.sv
module tb_demux8_router;

  localparam int unsigned SIZE      = 8;
  localparam int unsigned STALL_W   = 16;
  localparam int unsigned STALL_MAX = (1 << STALL_W) - 1;
`ifdef DEMUX_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [SIZE-1:0]    in_data;
  logic [2:0]         in_code;
  logic               in_valid;
  logic               in_ready;
  logic [SIZE-1:0]    out_data;
  logic [7:0]         out_valid;
  logic [7:0]         out_ready;
  logic               busy;
  logic [STALL_W-1:0] stall_cnt;

  demux8_router #(.size(SIZE), .STALL_W(STALL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_code   (in_code),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an in-order queue of accepted words (capacity CAP),
  // the data last shown on the bus, and a saturating stall count.
  typedef struct {
    logic [2:0] code;
    logic [7:0] data;
  } word_t;

  word_t       mq[$];
  logic [7:0]  m_data;
  int unsigned m_stall;

  typedef struct {
    logic       iv;
    logic [2:0] code;
    logic [7:0] data;
    logic [7:0] ordy;
    logic [7:0] ov;
    logic [7:0] od;
    logic       ir;
    logic       bsy;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_valid();
    if (mq.size() == 0) return 8'h00;
    return 8'(1) << mq[0].code;
  endfunction

  function automatic logic m_ready();
`ifdef DEMUX_SKID_EN
    return mq.size() < CAP;
`else
    if (mq.size() == 0) return 1'b1;
    return out_ready[mq[0].code];
`endif
  endfunction

  task automatic sample();
    @(negedge clk);
  endtask

  // Computes this cycle's transfers from the current inputs, moves to the
  // next edge, then updates the model.
  task automatic advance();
    bit    ox;
    bit    ix;
    word_t w;
    ox     = (mq.size() != 0) && out_ready[mq[0].code];
    ix     = in_valid && m_ready();
    w.code = in_code;
    w.data = in_data;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_data  = 8'h00;
      m_stall = 0;
    end else begin
      if (mq.size() != 0 && !ox && m_stall < STALL_MAX) m_stall++;
      if (ox) void'(mq.pop_front());
      if (ix) mq.push_back(w);
      if (mq.size() != 0) m_data = mq[0].data;
    end
    #1;
  endtask

  task automatic check_model();
    check("rnd_out_valid", 32'(out_valid), 32'(m_valid()));
    check("rnd_out_data", 32'(out_data), 32'(m_data));
    check("rnd_in_ready", 32'(in_ready), 32'(m_ready()));
    check("rnd_busy", 32'(busy), 32'(mq.size() != 0));
    check("rnd_stall_cnt", 32'(stall_cnt), m_stall);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 8'hFF;
    advance();
    advance();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_code   = 3'd0;
    in_data   = 8'h00;
    out_ready = 8'hFF;
    mq.delete();
    m_data  = 8'h00;
    m_stall = 0;

    // Reset held 3 cycles, then released.
    repeat (3) advance();
    reset = 1'b0;
    sample();
    check("rst_out_valid", 32'(out_valid), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_data", 32'(out_data), 32'h00);
    advance();

    // Single word then an 8-word back-to-back stream.
    tbl[0] = '{1'b1, 3'd5, 8'hA5, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 3'd0, 8'h00, 8'hFF, 8'h20, 8'hA5, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 3'd0, 8'h00, 8'hFF, 8'h00, 8'hA5, 1'b1, 1'b0};
    for (int unsigned k = 0; k < 8; k++) begin
      tbl[3+k].iv   = 1'b1;
      tbl[3+k].code = 3'(k);
      tbl[3+k].data = 8'(8'h10 + k);
      tbl[3+k].ordy = 8'hFF;
      tbl[3+k].ov   = (k == 0) ? 8'h00 : 8'(8'h01 << (k - 1));
      tbl[3+k].od   = (k == 0) ? 8'hA5 : 8'(8'h0F + k);
      tbl[3+k].ir   = 1'b1;
      tbl[3+k].bsy  = (k != 0);
    end
    tbl[11] = '{1'b0, 3'd0, 8'h00, 8'hFF, 8'h80, 8'h17, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 3'd0, 8'h00, 8'hFF, 8'h00, 8'h17, 1'b1, 1'b0};
    for (int unsigned i = 0; i < 13; i++) begin
      in_valid  = tbl[i].iv;
      in_code   = tbl[i].code;
      in_data   = tbl[i].data;
      out_ready = tbl[i].ordy;
      sample();
      check("tbl_out_valid", 32'(out_valid), 32'(tbl[i].ov));
      check("tbl_out_data", 32'(out_data), 32'(tbl[i].od));
      check("tbl_in_ready", 32'(in_ready), 32'(tbl[i].ir));
      check("tbl_busy", 32'(busy), 32'(tbl[i].bsy));
      advance();
    end

    // Addressed sink stalls 5 cycles, then accepts.
    do_reset();
    in_valid  = 1'b1;
    in_code   = 3'd3;
    in_data   = 8'h5C;
    out_ready = 8'hFF;
    sample();
    advance();
    out_ready = 8'hF7;
    for (int unsigned i = 0; i < 5; i++) begin
`ifdef DEMUX_SKID_EN
      in_valid = (i == 0);
      in_code  = 3'd1;
      in_data  = 8'h77;
`else
      in_valid = 1'b0;
`endif
      sample();
      check("stall_out_valid", 32'(out_valid), 32'h08);
      check("stall_out_data", 32'(out_data), 32'h5C);
      check("stall_cnt_ramp", 32'(stall_cnt), i);
`ifdef DEMUX_SKID_EN
      check("stall_in_ready", 32'(in_ready), (i == 0) ? 32'h1 : 32'h0);
`else
      check("stall_in_ready", 32'(in_ready), 32'h0);
`endif
      advance();
    end
    in_valid  = 1'b0;
    out_ready = 8'hFF;
    sample();
    check("stall_cnt_5", 32'(stall_cnt), 32'd5);
    check("release_out_valid", 32'(out_valid), 32'h08);
    check("release_out_data", 32'(out_data), 32'h5C);
    advance();
`ifdef DEMUX_SKID_EN
    sample();
    check("skid_out_valid", 32'(out_valid), 32'h02);
    check("skid_out_data", 32'(out_data), 32'h77);
    advance();
`endif
    sample();
    check("drained_out_valid", 32'(out_valid), 32'h00);
    check("drained_busy", 32'(busy), 32'h0);
    advance();

    // Stall counter saturation: 2^STALL_W + 3 stalled cycles.
    do_reset();
    in_valid  = 1'b1;
    in_code   = 3'd0;
    in_data   = 8'h3C;
    out_ready = 8'hFF;
    sample();
    advance();
    in_valid  = 1'b0;
    out_ready = 8'h00;
    repeat (STALL_MAX) advance();
    sample();
    check("sat_reach_max", 32'(stall_cnt), STALL_MAX);
    repeat (4) advance();
    sample();
    check("sat_no_wrap", 32'(stall_cnt), STALL_MAX);
    check("sat_out_valid", 32'(out_valid), 32'h01);

    // Reset while holding word(s): nothing is delivered afterwards.
    do_reset();
    in_valid  = 1'b1;
    in_code   = 3'd6;
    in_data   = 8'hE1;
    out_ready = 8'hFF;
    sample();
    advance();
    out_ready = 8'h00;
`ifdef DEMUX_SKID_EN
    in_code = 3'd2;
    in_data = 8'h4D;
`else
    in_valid = 1'b0;
`endif
    sample();
    advance();
    in_valid = 1'b0;
    sample();
    check("pre_rst_out_valid", 32'(out_valid), 32'h40);
    check("pre_rst_busy", 32'(busy), 32'h1);
    advance();
    reset = 1'b1;
    advance();
    reset     = 1'b0;
    out_ready = 8'hFF;
    for (int unsigned i = 0; i < 3; i++) begin
      sample();
      check("mid_rst_out_valid", 32'(out_valid), 32'h00);
      check("mid_rst_busy", 32'(busy), 32'h0);
      advance();
    end

    // Randomized traffic against the queue model.
    do_reset();
    for (int unsigned n = 0; n < 4000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_code   = 3'($urandom_range(0, 7));
      in_data   = 8'($urandom);
      out_ready = 8'($urandom | $urandom);
      sample();
      if (!reset) check_model();
      advance();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
